// File: rtl/ga_pkg.sv
// Shared GA constants and enums used by the answer packer and unpacker.
// The state and error encodings are fixed so the err_code port is stable.
package ga_pkg;
  localparam int NUM_CITIES = 30;
  localparam int CITY_W     = 5;
  localparam int BYTE_W     = 8;
  localparam int PATH_W     = NUM_CITIES * CITY_W;
  localparam int ANSWER_W   = 240;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_HIGH  = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_DUP   = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    HOLD    = 2'd2
  } state_t;
endpackage

// File: rtl/answer_byte_check.sv
// Combinational validation of one tour byte as a permutation element.
// The checks are prioritised: high bits, then range, then duplicate.
module answer_byte_check
  import ga_pkg::*;
#(
  parameter int NUM_CITIES = ga_pkg::NUM_CITIES,
  parameter int CITY_W     = ga_pkg::CITY_W,
  parameter int BYTE_W     = ga_pkg::BYTE_W
) (
  input  logic [BYTE_W-1:0]     byte_i,
  input  logic [NUM_CITIES-1:0] seen_i,
  output logic                  ok_o,
  output err_code_t             code_o
);

  logic [CITY_W-1:0] city;
  assign city = byte_i[CITY_W-1:0];

  always_comb begin
    code_o = ERR_NONE;
    if (|byte_i[BYTE_W-1:CITY_W]) begin
      code_o = ERR_HIGH;
    end else if (int'(city) >= NUM_CITIES) begin
      code_o = ERR_RANGE;
    end else if (seen_i[city]) begin
      code_o = ERR_DUP;
    end
    ok_o = (code_o == ERR_NONE);
  end

endmodule

// File: rtl/answer_unpack.sv
// Byte-stream receiver that rebuilds a 150-bit population-slot path from a
// 30-byte tour, validating each byte and holding the result for the loader.
module answer_unpack
  import ga_pkg::*;
#(
  parameter int NUM_CITIES = ga_pkg::NUM_CITIES,
  parameter int CITY_W     = ga_pkg::CITY_W,
  parameter int BYTE_W     = ga_pkg::BYTE_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BYTE_W-1:0]            byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic [NUM_CITIES*CITY_W-1:0] path_out,
  output logic                         path_valid,
  input  logic                         path_ready,
  output logic                         path_err,
  output logic [1:0]                   err_code,
  output logic [CITY_W-1:0]            err_pos,
  output state_t                       dbg_state
);

  localparam int PW = NUM_CITIES * CITY_W;

  // Handshakes: a byte moves when byte_valid && byte_ready at a rising edge,
  // a path moves when path_valid && path_ready; ready/valid are state decodes.
  state_t                state_q, state_d;
  logic [CITY_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CITIES-1:0] seen_q, seen_d;
  logic [PW-1:0]         path_q, path_d;
  logic                  err_q, err_d;
  err_code_t             code_q, code_d;
  logic [CITY_W-1:0]     pos_q, pos_d;

  logic                  chk_ok;
  err_code_t             chk_code;
  logic                  accept;
  logic                  last_byte;
  logic [CITY_W-1:0]     city;

  answer_byte_check #(
    .NUM_CITIES(NUM_CITIES),
    .CITY_W    (CITY_W),
    .BYTE_W    (BYTE_W)
  ) u_check (
    .byte_i (byte_in),
    .seen_i (seen_q),
    .ok_o   (chk_ok),
    .code_o (chk_code)
  );

  assign city      = byte_in[CITY_W-1:0];
  assign accept    = byte_valid && (state_q != HOLD);
  assign last_byte = (cnt_q == CITY_W'(NUM_CITIES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    path_d  = path_q;
    err_d   = err_q;
    code_d  = code_q;
    pos_d   = pos_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          cnt_d = cnt_q + CITY_W'(1);
          // The previous path survives until the first byte of a new frame.
          if (cnt_q == '0) begin
            path_d = '0;
          end
          if (chk_ok) begin
            for (int k = 0; k < NUM_CITIES; k++) begin
              if (cnt_q == CITY_W'(k)) begin
                path_d[PW-1-k*CITY_W -: CITY_W] = city;
              end
            end
            seen_d[city] = 1'b1;
          end else begin
            err_d   = 1'b1;
            code_d  = chk_code;
            pos_d   = cnt_q;
            state_d = FLUSH;
          end
          if (last_byte) begin
            state_d = HOLD;
          end
        end
      end
      FLUSH: begin
        if (accept) begin
          cnt_d = cnt_q + CITY_W'(1);
          if (last_byte) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (path_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          seen_d  = '0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          pos_d   = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      seen_q  <= '0;
      path_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      path_q  <= path_d;
      err_q   <= err_d;
      code_q  <= code_d;
      pos_q   <= pos_d;
    end
  end

  assign byte_ready = (state_q != HOLD);
  assign path_valid = (state_q == HOLD);
  assign path_out   = path_q;
  assign path_err   = err_q;
  assign err_code   = code_q;
  assign err_pos    = pos_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_answer_unpack.sv
// Directed frame-table bench for answer_unpack with expected-path queue.
module tb_answer_unpack;
  import ga_pkg::*;

  localparam int N  = 30;
  localparam int CW = 5;
  localparam int BW = 8;
  localparam int PW = N * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [PW-1:0] path_out;
  logic          path_valid;
  logic          path_ready = 1'b0;
  logic          path_err;
  logic [1:0]    err_code;
  logic [CW-1:0] err_pos;
  state_t        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  typedef struct packed {
    logic [239:0] bytes;
    logic [7:0]   stall;
    logic         exp_err;
    logic [1:0]   exp_code;
    logic [4:0]   exp_pos;
  } vec_t;

  vec_t vecs[9];

  answer_unpack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .path_out   (path_out),
    .path_valid (path_valid),
    .path_ready (path_ready),
    .path_err   (path_err),
    .err_code   (err_code),
    .err_pos    (err_pos),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [239:0] mk_tour(input int mode);
    logic [239:0] t;
    int c;
    t = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       c = k;
        1:       c = N - 1 - k;
        default: c = (7 * k) % N;
      endcase
      t[239-8*k -: 8] = 8'(c);
    end
    return t;
  endfunction

  function automatic logic [239:0] put(input logic [239:0] t, input int k, input logic [7:0] b);
    logic [239:0] r;
    r = t;
    r[239-8*k -: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get(input logic [239:0] t, input int k);
    return t[239-8*k -: 8];
  endfunction

  function automatic logic [PW-1:0] exp_path(input vec_t v);
    logic [PW-1:0] p;
    logic [7:0] b;
    p = '0;
    for (int k = 0; k < N; k++) begin
      b = get(v.bytes, k);
      if (!v.exp_err || k < int'(v.exp_pos)) p[PW-1-5*k -: 5] = b[4:0];
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: byte_ready stayed 0 for %0d cycles, required 1", guard);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [PW-1:0] exp;
    logic [PW-1:0] held;
    exp_q.push_back(exp_path(v));
    path_ready = (v.stall == 0);
    for (int k = 0; k < N; k++) begin
      send_byte(get(v.bytes, k));
      if (k == N - 2) chk({tag, "_valid_early"}, path_valid, 0);
    end
    exp = exp_q.pop_front();
    chk({tag, "_valid"}, path_valid, 1);
    chk({tag, "_ready_low"}, byte_ready, 0);
    chk({tag, "_path"}, path_out, exp);
    chk({tag, "_err"}, path_err, v.exp_err);
    chk({tag, "_code"}, err_code, v.exp_code);
    chk({tag, "_pos"}, err_pos, v.exp_pos);
    held = path_out;
    for (int s = 0; s < int'(v.stall); s++) begin
      // A byte offered during HOLD must not be consumed.
      if (s == 0) begin
        byte_valid = 1'b1;
        byte_in    = 8'h1D;
      end
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, path_valid, 1);
      chk({tag, "_hold_ready"}, byte_ready, 0);
      chk({tag, "_hold_path"}, path_out, held);
    end
    path_ready = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk({tag, "_rel_ready"}, byte_ready, 1);
    chk({tag, "_rel_valid"}, path_valid, 0);
    chk({tag, "_rel_err"}, path_err, 0);
    chk({tag, "_rel_code"}, err_code, 0);
    chk({tag, "_rel_path"}, path_out, exp);
    path_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [239:0] t;
    vec_t rv;

    vecs[0] = '{bytes: mk_tour(0), stall: 8'd0, exp_err: 1'b0, exp_code: 2'd0, exp_pos: 5'd0};
    vecs[1] = '{bytes: mk_tour(1), stall: 8'd5, exp_err: 1'b0, exp_code: 2'd0, exp_pos: 5'd0};
    vecs[2] = '{bytes: put(mk_tour(0), 3, 8'h25), stall: 8'd0, exp_err: 1'b1, exp_code: 2'd1, exp_pos: 5'd3};
    vecs[3] = '{bytes: put(mk_tour(0), 10, 8'h1E), stall: 8'd0, exp_err: 1'b1, exp_code: 2'd2, exp_pos: 5'd10};
    vecs[4] = '{bytes: mk_tour(0), stall: 8'd0, exp_err: 1'b0, exp_code: 2'd0, exp_pos: 5'd0};
    t = put(mk_tour(0), 2, 8'h04);
    t = put(t, 4, 8'h02);
    t = put(t, 7, 8'h04);
    t = put(t, 12, 8'h40);
    vecs[5] = '{bytes: t, stall: 8'd2, exp_err: 1'b1, exp_code: 2'd3, exp_pos: 5'd7};
    vecs[6] = '{bytes: put(mk_tour(0), 29, 8'h00), stall: 8'd0, exp_err: 1'b1, exp_code: 2'd3, exp_pos: 5'd29};
    vecs[7] = '{bytes: put(mk_tour(0), 0, 8'hFF), stall: 8'd1, exp_err: 1'b1, exp_code: 2'd1, exp_pos: 5'd0};
    vecs[8] = '{bytes: mk_tour(2), stall: 8'd0, exp_err: 1'b0, exp_code: 2'd0, exp_pos: 5'd0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", byte_ready, 1);
    chk("rst_valid", path_valid, 0);
    chk("rst_path", path_out, 0);
    chk("rst_err", path_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_pos", err_pos, 0);
    chk("rst_state", dbg_state, COLLECT);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // reset in the middle of a frame discards the partial tour
    t = mk_tour(0);
    for (int k = 0; k < 15; k++) send_byte(get(t, k));
    rst_n = 1'b0;
    #2;
    chk("midrst_path", path_out, 0);
    chk("midrst_valid", path_valid, 0);
    chk("midrst_ready", byte_ready, 1);
    chk("midrst_state", dbg_state, COLLECT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rv = '{bytes: mk_tour(1), stall: 8'd0, exp_err: 1'b0, exp_code: 2'd0, exp_pos: 5'd0};
    run_vec(rv, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
